// File: rtl/apb_slv_pkg.sv
// apb_slave_if shared types: FSM states, counter width, alignment and pprot constants.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int WAIT_CNT_W = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int PPROT_PRIV_BIT = 0;

  function automatic logic is_aligned(input logic [1:0] a);
    return (a & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/apb_slv_wait_cnt.sv
// Loadable down-counter for APB wait states; done flags the last wait cycle.
module apb_slv_wait_cnt
  import apb_slv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  dec,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  done
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_slave_if.sv
// APB4 slave engine: SETUP/ACCESS to single-cycle register strobes, registered response.
// Optional APB_SLV_PPROT_CHECK_EN adds pprot and rejects unprivileged writes.
module apb_slave_if
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`ifdef APB_SLV_PPROT_CHECK_EN
  input  logic [2:0]              pprot,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic                    reg_rd,
  output logic                    reg_wr,
  output logic [DATA_WIDTH/8-1:0] reg_strb,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_err
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;
  logic                  err_hold_q, err_hold_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic setup, issue, access, aligned, priv_ok, wait_done, resp_next;

`ifdef APB_SLV_PPROT_CHECK_EN
  logic [2:0] prot_q, prot_d;
`endif

  generate
    if (WAIT_CYCLES > 0) begin : g_wait
      apb_slv_wait_cnt u_wait_cnt (
        .clk      (pclk),
        .rst      (rst),
        .load     (state_q == ISSUE),
        .dec      (state_q == WAIT),
        .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
        .done     (wait_done)
      );
    end else begin : g_no_wait
      assign wait_done = 1'b0;
    end
  endgenerate

  assign setup   = (state_q == IDLE) && psel && !penable;
  assign issue   = (state_q == ISSUE);
  assign access  = psel && penable;
  assign aligned = is_aligned(addr_q[1:0]);

`ifdef APB_SLV_PPROT_CHECK_EN
  assign priv_ok = !wr_q || prot_q[PPROT_PRIV_BIT];
`else
  assign priv_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) state_d = ISSUE;
      end
      ISSUE: begin
        if (!access)               state_d = IDLE;
        else if (WAIT_CYCLES == 0) state_d = RESP;
        else                       state_d = WAIT;
      end
      WAIT: begin
        if (!access)        state_d = IDLE;
        else if (wait_done) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data is computed from the *_d holds so WAIT_CYCLES=0 sees this cycle's sample.
  always_comb begin
    addr_d       = setup ? paddr : addr_q;
    wr_d         = setup ? pwrite : wr_q;
    wdata_d      = setup ? pwdata : wdata_q;
    strb_d       = strb_q;
    if (setup) strb_d = pwrite ? pstrb : '0;
    rdata_hold_d = (issue && !wr_q) ? reg_rdata : rdata_hold_q;
    err_hold_d   = issue ? (!aligned || reg_err || !priv_ok) : err_hold_q;
    resp_next    = (state_d == RESP);
    pready_d     = resp_next;
    pslverr_d    = resp_next && err_hold_d;
    prdata_d     = (resp_next && !wr_q) ? rdata_hold_d : '0;
    reg_rd       = issue && aligned && !wr_q;
    reg_wr       = issue && aligned && wr_q && priv_ok;
  end

`ifdef APB_SLV_PPROT_CHECK_EN
  assign prot_d = setup ? pprot : prot_q;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
      prdata_q     <= '0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
`ifdef APB_SLV_PPROT_CHECK_EN
      prot_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      rdata_hold_q <= rdata_hold_d;
      err_hold_q   <= err_hold_d;
      prdata_q     <= prdata_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
`ifdef APB_SLV_PPROT_CHECK_EN
      prot_q       <= prot_d;
`endif
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign reg_addr  = addr_q;
  assign reg_strb  = strb_q;
  assign reg_wdata = wdata_q;

endmodule
